// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg -- shared definitions for the configuration frame sink.
//
// Contents:
//   CFG_FRAME_W, CFG_NUM_FRAMES : default frame geometry of the fabric
//   CRC16_POLY, CRC16_INIT      : CRC-16-CCITT constants
//   cfg_state_t                 : receiver FSM states
//   fold16()                    : XOR-fold of one frame word down to 16 bits
//   crc16_step()                : one 16-bit-wide CRC-16-CCITT update, MSB first
//
// The CRC helpers are only exercised when CONFIG_CRC_EN is defined.
// -----------------------------------------------------------------------------
package cfg_pkg;

   localparam int          CFG_FRAME_W    = 320;
   localparam int          CFG_NUM_FRAMES = 172;
   localparam logic [15:0] CRC16_POLY     = 16'h1021;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      ERR
   } cfg_state_t;

   // XOR of all 16-bit slices of the frame; a partial top slice is zero-padded.
   function automatic logic [15:0] fold16(input logic [CFG_FRAME_W-1:0] frame);
      logic [15:0] acc;
      acc = '0;
      for (int i = 0; i < (CFG_FRAME_W + 15) / 16; i++) begin
         acc ^= 16'(frame >> (16 * i));
      end
      return acc;
   endfunction

   // Shift 16 data bits (MSB first) through the CCITT polynomial.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic [15:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0};
         if (fb) c ^= CRC16_POLY;
      end
      return c;
   endfunction

endpackage

// File: rtl/cfg_crc16.sv
// -----------------------------------------------------------------------------
// cfg_crc16 -- running CRC-16-CCITT over committed configuration frames.
// Each enabled cycle folds the frame to 16 bits and advances the CRC by one
// step. Instantiated by config_frame_sink only when CONFIG_CRC_EN is defined.
//
// Ports:
//   clock     in   system clock
//   rst       in   asynchronous active-low reset (CRC returns to CRC16_INIT)
//   clear     in   synchronous restart of the CRC at the start of a load
//   enable    in   advance the CRC with `frame` (one pulse per commit)
//   frame     in   FRAME_W frame contents being committed
//   crc       out  current CRC value
//   crc_next  out  CRC value after folding in `frame` (combinational)
// -----------------------------------------------------------------------------
module cfg_crc16
   import cfg_pkg::*;
#(
   parameter int FRAME_W = CFG_FRAME_W
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   input  logic [FRAME_W-1:0] frame,
   output logic [15:0]        crc,
   output logic [15:0]        crc_next
);

   logic [CFG_FRAME_W-1:0] frame_pad;

   assign frame_pad = CFG_FRAME_W'(frame);
   assign crc_next  = crc16_step(crc, fold16(frame_pad));

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         crc <= CRC16_INIT;
      end else if (clear) begin
         crc <= CRC16_INIT;
      end else if (enable) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/config_frame_sink.sv
// -----------------------------------------------------------------------------
// config_frame_sink -- fabric-side receiver of the configuration load stream.
//
// The driver walks a one-hot select across NUM_FRAMES frames; each time the
// select moves on, the frame that was just selected is written to tile config
// storage one cycle later. Protocol violations latch an error until reset;
// a clean load raises cfg_done and then ff_en_out.
//
// Ports:
//   clock          in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   configs_in     in   FRAME_W frame data from the config driver
//   configs_en     in   NUM_FRAMES one-hot frame select (zero after last frame)
//   crc_expect     in   16-bit expected CRC        (CONFIG_CRC_EN only)
//   crc_ok         out  CRC matched on completion   (CONFIG_CRC_EN only)
//   frame_we       out  one-cycle write strobe
//   frame_addr     out  ADDR_W index of the frame being written
//   frame_data     out  FRAME_W committed frame contents
//   frames_loaded  out  ADDR_W+1 count of committed frames
//   cfg_done       out  all frames committed with a clean protocol
//   cfg_err        out  sticky protocol violation
//   ff_en_out      out  user-flop enable, one cycle after cfg_done
//
// Build option: define CONFIG_CRC_EN to add the CRC check on completion.
// ADDR_W must satisfy 2**ADDR_W >= NUM_FRAMES.
// -----------------------------------------------------------------------------
module config_frame_sink
   import cfg_pkg::*;
#(
   parameter int FRAME_W    = CFG_FRAME_W,
   parameter int NUM_FRAMES = CFG_NUM_FRAMES,
   parameter int ADDR_W     = 8
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [FRAME_W-1:0]    configs_in,
   input  logic [NUM_FRAMES-1:0] configs_en,
`ifdef CONFIG_CRC_EN
   input  logic [15:0]           crc_expect,
   output logic                  crc_ok,
`endif
   output logic                  frame_we,
   output logic [ADDR_W-1:0]     frame_addr,
   output logic [FRAME_W-1:0]    frame_data,
   output logic [ADDR_W:0]       frames_loaded,
   output logic                  cfg_done,
   output logic                  cfg_err,
   output logic                  ff_en_out
);

   cfg_state_t            state, state_next;
   logic [NUM_FRAMES-1:0] en_q;
   logic [FRAME_W-1:0]    data_q;
   logic [ADDR_W-1:0]     idx;

   logic                  advance;
   logic                  step_ok;
   logic                  last_frame;
   logic                  commit;
   logic                  start_load;
   logic                  crc_pass;

   // The frame index is the commit count; it never exceeds NUM_FRAMES-1
   // while a write is still pending.
   assign idx        = frames_loaded[ADDR_W-1:0];
   assign advance    = (configs_en != en_q) && (en_q != '0);
   assign last_frame = (idx == ADDR_W'(NUM_FRAMES - 1));
   // The select must move exactly one place up; falling off the top end is
   // only legal when the last frame was the one selected.
   assign step_ok    = (configs_en == (en_q << 1)) &&
                       ((configs_en != '0) || last_frame);
   assign cfg_err    = (state == ERR);

`ifdef CONFIG_CRC_EN
   logic [15:0] crc_cur;
   logic [15:0] crc_next;

   cfg_crc16 #(
      .FRAME_W (FRAME_W)
   ) u_crc (
      .clock    (clock),
      .rst      (rst),
      .clear    (start_load),
      .enable   (commit),
      .frame    (data_q),
      .crc      (crc_cur),
      .crc_next (crc_next)
   );

   // The final commit is checked using the CRC value that includes it.
   assign crc_pass = (crc_next == crc_expect);
`else
   assign crc_pass = 1'b1;
`endif

   // State register.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_next = state;
      commit     = 1'b0;
      start_load = 1'b0;
      case (state)
         IDLE: begin
            if (configs_en == NUM_FRAMES'(1)) begin
               state_next = LOAD;
               start_load = 1'b1;
            end else if (configs_en != '0) begin
               state_next = ERR;
            end
         end
         LOAD: begin
            if (advance) begin
               if (step_ok) begin
                  commit = 1'b1;
                  if (configs_en == '0) state_next = crc_pass ? DONE : ERR;
               end else begin
                  state_next = ERR;
               end
            end
         end
         DONE: begin
            if (configs_en != '0) state_next = ERR;
         end
         default: begin
            state_next = ERR;
         end
      endcase
   end

   // Input pipeline, write port and status outputs.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         en_q          <= '0;
         data_q        <= '0;
         frame_we      <= 1'b0;
         frame_addr    <= '0;
         frame_data    <= '0;
         frames_loaded <= '0;
         cfg_done      <= 1'b0;
         ff_en_out     <= 1'b0;
`ifdef CONFIG_CRC_EN
         crc_ok        <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments here, so every register samples the
         // pre-edge value of the others regardless of statement order.
         en_q     <= configs_en;
         data_q   <= configs_in;
         frame_we <= commit;
         if (start_load) begin
            frames_loaded <= '0;
         end else if (commit) begin
            frame_addr    <= idx;
            frame_data    <= data_q;
            frames_loaded <= frames_loaded + 1'b1;
         end
         // Done follows the final write by one cycle, the flop enable by two;
         // both drop in the same cycle the FSM falls into ERR.
         cfg_done  <= (state == DONE) && (state_next == DONE);
         ff_en_out <= cfg_done && (state_next == DONE);
`ifdef CONFIG_CRC_EN
         if (state_next == ERR) begin
            crc_ok <= 1'b0;
         end else if (commit && (state_next == DONE)) begin
            crc_ok <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: doc/config_frame_sink.md
Name: config_frame_sink

Overview:
- Fabric-side receiver for the configuration load interface.
- Per cycle it accepts a frame word (`configs_in`) and a walking one-hot frame select (`configs_en`). It commits each frame to a downstream tile-config write port when the select advances.
- It checks protocol sanity and raises `cfg_done`/`ff_en_out` once every frame has landed.
- Sits between the config driver and the tile configuration storage of `fpga`.

Parameters:
- FRAME_W, 320, width of one configuration frame word.
- NUM_FRAMES, 172, number of frames (width of the `configs_en` one-hot).
- ADDR_W, 8, frame address width; must satisfy 2**ADDR_W >= NUM_FRAMES.

Ports:
- clock  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- configs_in  input  FRAME_W  frame data from the config driver.
- configs_en  input  NUM_FRAMES  one-hot frame select; bit0 at start, shifted left once per frame, all-zero after the last frame.
- frame_we  output  1  one-cycle write strobe to tile config storage.
- frame_addr  output  ADDR_W  index of the frame being written.
- frame_data  output  FRAME_W  committed frame contents.
- frames_loaded  output  ADDR_W+1  count of committed frames.
- cfg_done  output  1  all NUM_FRAMES frames committed, protocol clean.
- cfg_err  output  1  sticky protocol violation.
- ff_en_out  output  1  user-flop enable; permitted only after a clean load.

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; en_q=0, data_q=0, idx=0.
- Registers, every cycle:
  - en_q <= configs_en; data_q <= configs_in.
  - "advance" = configs_en != en_q, with en_q nonzero.
- States:
  - IDLE:
    - configs_en==1 -> LOAD, idx=0.
    - Any other nonzero value -> ERR.
    - Zero -> stay.
  - LOAD, on advance:
    - Legal iff configs_en == en_q<<1, truncated to NUM_FRAMES; the truncated-to-zero case is legal only when idx==NUM_FRAMES-1.
    - Legal: next cycle frame_we=1, frame_addr=idx, frame_data=data_q; idx++, frames_loaded++.
    - Illegal: -> ERR; no write issued.
    - Legal advance to zero: -> DONE (the final commit still issues).
  - LOAD, no advance: configs_en must remain equal to en_q (a mid-load change to a non-one-hot value is illegal); configs_in may change freely.
  - DONE:
    - cfg_done=1 the cycle after the last frame_we; ff_en_out=1 one cycle after cfg_done.
    - Any nonzero configs_en -> ERR. Outputs hold otherwise.
  - ERR: cfg_err=1; cfg_done=0; ff_en_out=0; no further writes; exit only via reset.
- Commit latency: frame_we exactly one cycle after the cycle in which the advance is sampled. Data is the configs_in value sampled one cycle before the advance (the driver updates data a cycle ahead of the select).
- frame_we is never asserted two consecutive cycles for the same address.
- Reset mid-load: everything clears; a new load must restart at configs_en==1.
- Truncated bitstream (select never reaches zero): stays in LOAD; cfg_done stays 0.

Optional Feature:
- Macro: `CONFIG_CRC_EN`.
- Defined:
  - Ports `crc_expect` (input, 16) and `crc_ok` (output, 1) exist.
  - Each committed frame is XOR-folded to 16 bits; a CRC-16-CCITT (poly 0x1021, init 0xFFFF) is updated once per commit.
  - On entry to DONE, crc_ok=(crc==crc_expect). If they mismatch, the next state is ERR instead of DONE, and cfg_done/ff_en_out never assert.
- Not defined: no CRC logic or ports; DONE is reached on protocol checks alone.

Decomposition:
- Shared package `cfg_pkg`:
  - Constants: CFG_FRAME_W=320, CFG_NUM_FRAMES=172, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF.
  - Typedef `cfg_state_t` {IDLE, LOAD, DONE, ERR}.
  - Function `fold16` (FRAME_W -> 16).
- One sub-module: `cfg_crc16` (fold + one-step CRC update, clear/enable inputs), instantiated only under `CONFIG_CRC_EN`.

Test Plan:
- Clean load:
  - Stimulus: 172 frames, data=frame index replicated, one frame every 2 clocks.
  - Required: 172 frame_we pulses with addr 0..171 and matching data; frames_loaded=172; cfg_done then ff_en_out on consecutive cycles; cfg_err=0.
- Skip:
  - Stimulus: configs_en jumps from bit5 to bit7.
  - Required: cfg_err=1 next cycle; frames_loaded stays 5; no further frame_we.
- Non-one-hot:
  - Stimulus: configs_en=3 in IDLE.
  - Required: ERR; cfg_err=1; cfg_done never asserts.
- Reset mid-load:
  - Stimulus: assert rst low asynchronously after frame 40, then reload fully.
  - Required: outputs 0 immediately; second load completes with frames_loaded=172.
- Truncated:
  - Stimulus: stop after 100 frames with configs_en held at bit100.
  - Required: frames_loaded=100; cfg_done=0 indefinitely.
- CRC (with `CONFIG_CRC_EN`):
  - Correct crc_expect: crc_ok=1 and cfg_done=1.
  - crc_expect with bit0 flipped: cfg_err=1 and ff_en_out=0.
